// File: rtl/fetch_sequencer.sv
// Host-driven fetch control: loads a program byte stream into instruction memory,
// then runs it continuously or single-stepped, draining the pipeline at program end.
module fetch_sequencer #(
    parameter int NB_BYTE      = 8,
    parameter int MEM_BYTES    = 128,
    parameter int DRAIN_CYCLES = 5
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    input  logic               i_is_end,
    output logic [NB_BYTE-1:0] o_load_byte,
    output logic               o_load_write_enable,
    output logic               o_pc_reset,
    output logic               o_enable,
    output logic [2:0]         o_state,
    output logic [7:0]         o_byte_count,
    output logic               o_done
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        RUN       = 3'd2,
        STEP_WAIT = 3'd3,
        STEP_EXEC = 3'd4,
        DRAIN     = 3'd5,
        DONE      = 3'd6
    } state_t;

    localparam logic [NB_BYTE-1:0] CMD_L = NB_BYTE'(8'h4C);
    localparam logic [NB_BYTE-1:0] CMD_C = NB_BYTE'(8'h43);
    localparam logic [NB_BYTE-1:0] CMD_S = NB_BYTE'(8'h53);
    localparam logic [NB_BYTE-1:0] CMD_N = NB_BYTE'(8'h4E);
    localparam logic [NB_BYTE-1:0] CMD_X = NB_BYTE'(8'h58);
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t         state, state_next;
    logic [DCW-1:0] drain_count;
    logic           ff_run;        // every byte so far in the current aligned word was all-ones
    logic           load_end_pend; // delays the post-load pc_reset by one cycle
    logic           load_accept, load_last, start_pc, clear_count, ff_byte, is_abort;

    assign ff_byte  = (i_rx_data == {NB_BYTE{1'b1}});
    assign is_abort = i_rx_valid && (i_rx_data == CMD_X);

    always_ff @(posedge i_clock) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next  = state;
        load_accept = 1'b0;
        load_last   = 1'b0;
        start_pc    = 1'b0;
        clear_count = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_L) begin
                        state_next  = LOAD;
                        clear_count = 1'b1;
                    end else if (i_rx_data == CMD_C) begin
                        state_next = RUN;
                        start_pc   = 1'b1;
                    end else if (i_rx_data == CMD_S) begin
                        state_next = STEP_WAIT;
                        start_pc   = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (i_rx_valid) begin
                    load_accept = 1'b1;
                    if ((o_byte_count[1:0] == 2'd3 && ff_run && ff_byte) ||
                        (o_byte_count == 8'(MEM_BYTES - 1))) begin
                        load_last  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            RUN: begin
                if (is_abort)      state_next = IDLE;
                else if (i_is_end) state_next = DRAIN;
            end
            STEP_WAIT: begin
                if (is_abort)                                state_next = IDLE;
                else if (i_rx_valid && i_rx_data == CMD_N)   state_next = STEP_EXEC;
            end
            STEP_EXEC: begin
                if (is_abort)      state_next = IDLE;
                else if (i_is_end) state_next = DRAIN;
                else               state_next = STEP_WAIT;
            end
            DRAIN: begin
                if (drain_count == DCW'(DRAIN_CYCLES - 1)) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            drain_count         <= '0;
            ff_run              <= 1'b0;
            load_end_pend       <= 1'b0;
            o_byte_count        <= '0;
            o_load_byte         <= '0;
            o_load_write_enable <= 1'b0;
            o_pc_reset          <= 1'b0;
        end else begin
            drain_count         <= (state == DRAIN) ? drain_count + 1'b1 : '0;
            load_end_pend       <= load_last;
            o_pc_reset          <= start_pc | load_end_pend;
            o_load_write_enable <= load_accept;
            if (load_accept) begin
                o_load_byte  <= i_rx_data;
                o_byte_count <= o_byte_count + 8'd1;
                ff_run       <= (o_byte_count[1:0] == 2'd0) ? ff_byte : (ff_run & ff_byte);
            end
            if (clear_count) begin
                o_byte_count <= '0;
                ff_run       <= 1'b0;
            end
        end
    end

    assign o_state  = state;
    assign o_enable = (state == RUN) || (state == STEP_EXEC) || (state == DRAIN);
    assign o_done   = (state == DONE);

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter NB_BYTE, default 8: width of received bytes and program bytes.
REQ-002 Parameter MEM_BYTES, default 128: instruction memory capacity in bytes.
REQ-003 Parameter DRAIN_CYCLES, default 5: cycles the pipeline stays enabled after program end.
REQ-004 Port i_clock, input, 1: clock; all state changes on the rising edge.
REQ-005 Port i_reset, input, 1: reset, synchronous, active-high.
REQ-006 Port i_rx_data, input, NB_BYTE: byte from the host link.
REQ-007 Port i_rx_valid, input, 1: one-cycle strobe qualifying i_rx_data.
REQ-008 Port i_is_end, input, 1: program-end flag from the fetch stage.
REQ-009 Port o_load_byte, output, NB_BYTE: program byte to instruction memory.
REQ-010 Port o_load_write_enable, output, 1: write strobe to instruction memory.
REQ-011 Port o_pc_reset, output, 1: one-cycle PC clear pulse to the fetch stage.
REQ-012 Port o_enable, output, 1: pipeline advance enable (1 = PC/pipeline updates).
REQ-013 Port o_state, output, 3: current state encoding.
REQ-014 Port o_byte_count, output, 8: bytes written in the current load.
REQ-015 Port o_done, output, 1: high while in DONE.

Function
REQ-016 States and encodings SHALL be IDLE=0, LOAD=1, RUN=2, STEP_WAIT=3, STEP_EXEC=4, DRAIN=5, DONE=6; o_state is the state register.
REQ-017 Commands SHALL be recognised only on i_rx_valid=1: 'L'=0x4C, 'C'=0x43, 'S'=0x53, 'N'=0x4E, 'X'=0x58; any other byte outside LOAD is ignored.
REQ-018 In IDLE or DONE: 'L' goes to LOAD and clears o_byte_count; 'C' goes to RUN; 'S' goes to STEP_WAIT; every other byte, including 'N' and 'X', is ignored.
REQ-019 Entering RUN or STEP_WAIT from IDLE/DONE SHALL pulse o_pc_reset high for exactly the first cycle in the new state.
REQ-020 o_enable SHALL be combinational from state: 1 in RUN, STEP_EXEC, DRAIN; 0 otherwise.
REQ-021 In LOAD, each i_rx_valid byte SHALL be registered to o_load_byte with o_load_write_enable=1 on the next cycle, one strobe per byte; o_byte_count increments with the same timing.
REQ-022 Halt detection: when bytes at offsets 4k..4k+3 of the current load are all 0xFF, the load ends after that fourth byte is written.
REQ-023 The load also ends when o_byte_count reaches MEM_BYTES; further bytes are not written.
REQ-024 Load end: state goes to IDLE on the cycle the last write strobe is issued, and o_pc_reset pulses on the following cycle.
REQ-025 In LOAD, command codes are data and are written like any other byte.
REQ-026 In RUN, i_is_end=1 SHALL move to DRAIN on the next edge.
REQ-027 In STEP_WAIT, 'N' SHALL move to STEP_EXEC, which lasts exactly one cycle.
REQ-028 From STEP_EXEC, the next state is DRAIN if i_is_end=1 in that cycle, else STEP_WAIT.
REQ-029 DRAIN SHALL last exactly DRAIN_CYCLES cycles using an internal counter, then move to DONE; bytes received in DRAIN are ignored.
REQ-030 'X' in RUN, STEP_WAIT or STEP_EXEC SHALL move to IDLE on the next edge, with no pc_reset.
REQ-031 If 'X' and i_is_end=1 occur in the same cycle, abort SHALL win.
REQ-032 An 'N' arriving while in STEP_EXEC SHALL be dropped, not queued.
REQ-033 o_done SHALL equal (state==DONE).

Reset
REQ-034 On i_reset=1 at an edge: state=IDLE, drain counter=0, halt tracker=0, o_byte_count=0, o_load_byte=0, o_load_write_enable=0, o_pc_reset=0.
REQ-035 Reset SHALL override all other inputs, including in the middle of a load or a run; no pc_reset pulse results from reset.

Verification
REQ-036 Load: 'L', 00 11 22 33, FF FF FF FF -> 8 write strobes in byte order, o_byte_count=8, IDLE, then one o_pc_reset pulse.
REQ-037 Non-aligned FF: 'L', 11 FF FF FF FF 22 33 44 -> no early end (FFs straddle a word boundary); 8 bytes written and state stays LOAD.
REQ-038 Overflow: 'L' followed by 130 bytes of 0x01 -> exactly 128 strobes, then IDLE; bytes 129 and 130 are ignored.
REQ-039 Continuous run: 'C' -> pc_reset pulse and o_enable=1; i_is_end raised at cycle 10 -> DRAIN with enable held for 5 cycles, then DONE with o_done=1 and o_enable=0.
REQ-040 Step mode: 'S', then 'N' three times -> exactly three single-cycle o_enable pulses; 'N' with i_is_end=1 -> DRAIN then DONE.
REQ-041 Abort: 'C', then 'X' in the same cycle as i_is_end=1 -> IDLE, no DRAIN; i_reset asserted during LOAD -> all outputs are 0 on the next cycle.
